// File: rtl/output_port_requester_if.sv
// Handshake bundle between the output port requester, its two input channels,
// the rotating prioritizer and the downstream ring hop.
interface output_port_requester_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in0_si;
  logic                  in0_ri;
  logic [DATA_WIDTH-1:0] in0_di;
  logic                  in1_si;
  logic                  in1_ri;
  logic [DATA_WIDTH-1:0] in1_di;
  logic                  rq_0;
  logic                  rq_1;
  logic                  gt_0;
  logic                  gt_1;
  logic                  so;
  logic                  ro;
  // Output data; "do" is a reserved word, hence dout.
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    input  in0_si, in0_di, in1_si, in1_di, gt_0, gt_1, ro,
    output in0_ri, in1_ri, rq_0, rq_1, so, dout
  );

  modport slave (
    output in0_si, in0_di, in1_si, in1_di, gt_0, gt_1, ro,
    input  in0_ri, in1_ri, rq_0, rq_1, so, dout
  );
endinterface

// File: rtl/output_port_requester.sv
// Two-channel client of the rotating prioritizer: one packet buffer per input,
// a single output register draining over send/ready, sticky error and packet count.
module output_port_requester #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output_port_requester_if.master bus,
  output logic                    err,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);
  logic                  full0_q, full0_d, full1_q, full1_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  out_full_q, out_full_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic ofree, rq0, rq1, gt_both, mv0, mv1, drain;

  // Output is free when empty or being drained on this same edge.
  assign ofree   = ~out_full_q | bus.ro;
  assign rq0     = full0_q & ofree;
  assign rq1     = full1_q & ofree;
  assign gt_both = bus.gt_0 & bus.gt_1;
  assign mv0     = rq0 & bus.gt_0 & ~gt_both;
  assign mv1     = rq1 & bus.gt_1 & ~gt_both;
  assign drain   = out_full_q & bus.ro;

  assign bus.in0_ri = ~full0_q;
  assign bus.in1_ri = ~full1_q;
  assign bus.rq_0   = rq0;
  assign bus.rq_1   = rq1;
  assign bus.so     = out_full_q;
  assign bus.dout   = out_data_q;
  assign err        = err_q;
  assign pkt_cnt    = cnt_q;

  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    full0_d    = full0_q;
    full1_d    = full1_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q | gt_both | (bus.gt_0 & ~rq0) | (bus.gt_1 & ~rq1);

    if (bus.in0_si && !full0_q) begin
      buf0_d  = bus.in0_di;
      full0_d = 1'b1;
    end
    if (bus.in1_si && !full1_q) begin
      buf1_d  = bus.in1_di;
      full1_d = 1'b1;
    end

    // Drain first so a same-edge load below keeps the register full.
    if (drain) begin
      out_full_d = 1'b0;
      cnt_d      = cnt_q + CNT_WIDTH'(1);
    end
    if (mv0) begin
      out_data_d = buf0_q;
      out_full_d = 1'b1;
      full0_d    = 1'b0;
    end
    if (mv1) begin
      out_data_d = buf1_q;
      out_full_d = 1'b1;
      full1_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: data registers are reset too, since dout must read 0 out of reset.
      full0_q    <= 1'b0;
      full1_q    <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      out_full_q <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      full0_q    <= full0_d;
      full1_q    <= full1_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_output_port_requester.sv
// Directed bench: vector table for single packet, backpressure and grant errors,
// then a rotating-prioritizer stream, async reset, spurious grant and counter wrap.
module tb_output_port_requester;
  logic clk;
  logic reset;

  output_port_requester_if #(.DATA_WIDTH(64)) bus ();
  output_port_requester_if #(.DATA_WIDTH(64)) wbus ();

  logic        err, werr;
  logic [15:0] pkt_cnt;
  logic [3:0]  wpkt_cnt;

  output_port_requester #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err(err), .pkt_cnt(pkt_cnt)
  );

  output_port_requester #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_wrap (
    .clk(clk), .reset(reset), .bus(wbus), .err(werr), .pkt_cnt(wpkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant source: manual values or a rotating prioritizer starting at channel 0.
  logic use_arb, man_g0, man_g1, arb_g0, arb_g1, ptr;
  always_comb begin
    arb_g0   = bus.rq_0 & (~bus.rq_1 | ~ptr);
    arb_g1   = bus.rq_1 & (~bus.rq_0 | ptr);
    bus.gt_0 = use_arb ? arb_g0 : man_g0;
    bus.gt_1 = use_arb ? arb_g1 : man_g1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ptr <= 1'b0;
    else if (use_arb && arb_g0) ptr <= 1'b1;
    else if (use_arb && arb_g1) ptr <= 1'b0;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        si0;
    logic [63:0] d0;
    logic        si1;
    logic [63:0] d1;
    logic        ro, g0, g1;
    logic        ri0, ri1, rq0, rq1, so;
    logic [63:0] dout;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t v [NV];

  int n0, n1, got, gaps;
  logic started, acc0, acc1;

  initial begin
    // inputs: si0 d0 si1 d1 ro g0 g1 | expected: ri0 ri1 rq0 rq1 so dout err cnt
    v[0]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'h0, 1'b0,16'd0};
    v[1]  = '{1'b1,64'hA5,1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'h0, 1'b0,16'd0};
    v[2]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,64'h0, 1'b0,16'd0};
    v[3]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,64'hA5,1'b0,16'd0};
    v[4]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'hA5,1'b0,16'd1};
    v[5]  = '{1'b1,64'h11,1'b1,64'h22,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'hA5,1'b0,16'd1};
    v[6]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,64'hA5,1'b0,16'd1};
    v[7]  = '{1'b1,64'h33,1'b0,64'h0, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,64'h11,1'b0,16'd1};
    v[8]  = '{1'b0,64'h0, 1'b0,64'h0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,64'h11,1'b0,16'd1};
    v[9]  = v[8];
    v[10] = v[8];
    v[11] = v[8];
    v[12] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,64'h11,1'b0,16'd1};
    v[13] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1,64'h22,1'b0,16'd2};
    v[14] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,64'h33,1'b0,16'd3};
    v[15] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'h33,1'b0,16'd4};
    v[16] = '{1'b1,64'h44,1'b1,64'h55,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'h33,1'b0,16'd4};
    v[17] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,64'h33,1'b0,16'd4};
    v[18] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,64'h33,1'b1,16'd4};
    v[19] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,64'h33,1'b1,16'd4};
    v[20] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b1,64'h44,1'b1,16'd4};
    v[21] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,64'h55,1'b1,16'd5};
    v[22] = '{1'b0,64'h0, 1'b0,64'h0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,64'h55,1'b1,16'd6};

    use_arb = 1'b0; man_g0 = 1'b0; man_g1 = 1'b0;
    bus.in0_si = 1'b0; bus.in0_di = '0; bus.in1_si = 1'b0; bus.in1_di = '0; bus.ro = 1'b0;
    wbus.in0_si = 1'b0; wbus.in0_di = '0; wbus.in1_si = 1'b0; wbus.in1_di = '0;
    wbus.gt_0 = 1'b0; wbus.gt_1 = 1'b0; wbus.ro = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Vector table: single packet, backpressure, double grant.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.in0_si = v[i].si0; bus.in0_di = v[i].d0;
      bus.in1_si = v[i].si1; bus.in1_di = v[i].d1;
      bus.ro = v[i].ro; man_g0 = v[i].g0; man_g1 = v[i].g1;
      #1;
      check($sformatf("v%0d_in0_ri", i), 64'(bus.in0_ri), 64'(v[i].ri0));
      check($sformatf("v%0d_in1_ri", i), 64'(bus.in1_ri), 64'(v[i].ri1));
      check($sformatf("v%0d_rq_0", i),   64'(bus.rq_0),   64'(v[i].rq0));
      check($sformatf("v%0d_rq_1", i),   64'(bus.rq_1),   64'(v[i].rq1));
      check($sformatf("v%0d_so", i),     64'(bus.so),     64'(v[i].so));
      check($sformatf("v%0d_do", i),     bus.dout,        v[i].dout);
      check($sformatf("v%0d_err", i),    64'(err),        64'(v[i].err));
      check($sformatf("v%0d_pkt_cnt", i), 64'(pkt_cnt),   64'(v[i].cnt));
    end

    // Contention stream through the rotating prioritizer.
    man_g0 = 1'b0; man_g1 = 1'b0; use_arb = 1'b1;
    n0 = 1; n1 = 101; got = 0; gaps = 0; started = 1'b0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      @(negedge clk);
      bus.in0_si = 1'b1; bus.in0_di = 64'(n0);
      bus.in1_si = 1'b1; bus.in1_di = 64'(n1);
      bus.ro = 1'b1;
      #1;
      acc0 = bus.in0_ri; acc1 = bus.in1_ri;
      if (bus.so) begin
        check($sformatf("stream_pkt%0d", got), bus.dout,
              (got % 2 == 0) ? 64'(1 + got / 2) : 64'(101 + got / 2));
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      @(posedge clk);
      if (acc0) n0++;
      if (acc1) n1++;
    end
    @(negedge clk);
    bus.in0_si = 1'b0; bus.in1_si = 1'b0;
    #1;
    check("stream_delivered", 64'(got), 64'd20);
    check("stream_gaps", 64'(gaps), 64'd0);
    check("stream_pkt_cnt", 64'(pkt_cnt), 64'd26);
    check("stream_so_busy", 64'(bus.so), 64'd1);
    check("stream_rq_any", 64'(bus.rq_0 | bus.rq_1), 64'd1);

    // Asynchronous reset between edges with a packet on the output.
    #1 reset = 1'b0;
    #1;
    check("arst_so", 64'(bus.so), 64'd0);
    check("arst_rq_0", 64'(bus.rq_0), 64'd0);
    check("arst_rq_1", 64'(bus.rq_1), 64'd0);
    check("arst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_in0_ri", 64'(bus.in0_ri), 64'd1);
    check("arst_in1_ri", 64'(bus.in1_ri), 64'd1);
    check("arst_do", bus.dout, 64'd0);

    // Spurious grant on an idle channel.
    @(negedge clk);
    reset = 1'b1; use_arb = 1'b0; bus.ro = 1'b1; man_g1 = 1'b1;
    #1;
    check("spur_err_before", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    check("spur_err_after", 64'(err), 64'd1);
    check("spur_so", 64'(bus.so), 64'd0);
    check("spur_in1_ri", 64'(bus.in1_ri), 64'd1);
    @(negedge clk);
    man_g1 = 1'b0;
    @(posedge clk);
    #1;
    check("spur_err_sticky", 64'(err), 64'd1);

    // Counter wrap on the 4-bit instance: 17 packets through channel 0.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wbus.in0_si = 1'b1; wbus.in0_di = 64'(i + 1); wbus.gt_0 = 1'b0;
      @(negedge clk);
      wbus.in0_si = 1'b0; wbus.gt_0 = 1'b1;
      @(negedge clk);
      wbus.gt_0 = 1'b0;
    end
    @(negedge clk);
    #1;
    check("wrap_pkt_cnt", 64'(wpkt_cnt), 64'd1);
    check("wrap_last_do", wbus.dout, 64'd17);
    check("wrap_so_idle", 64'(wbus.so), 64'd0);
    check("wrap_err", 64'(werr), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
